// File: rtl/sat_trail_stack_if.sv
// Push, backtrack-stream and status bundle of the SAT assignment trail.
// The bt_level field exists only when TRAIL_BACKJUMP_EN is defined.
interface sat_trail_stack_if #(
    parameter int VAR_W = 7,
    parameter int CNT_W = 8
);
    logic             push_valid;
    logic             push_ready;
    logic             push_type;
    logic             push_val;
    logic [VAR_W-1:0] push_var;
    logic             bt_req;
    logic             bt_busy;
`ifdef TRAIL_BACKJUMP_EN
    logic [CNT_W-1:0] bt_level;
`endif
    logic             out_valid;
    logic             out_ready;
    logic             out_type;
    logic             out_val;
    logic [VAR_W-1:0] out_var;
    logic             out_last;
    logic             bt_done;
    logic             bt_empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] level;
    logic             full;
    logic             empty;
    logic             overflow;

    modport master (
        output push_valid, push_type, push_val, push_var, bt_req,
`ifdef TRAIL_BACKJUMP_EN
        output bt_level,
`endif
        output out_ready,
        input  push_ready, bt_busy, out_valid, out_type, out_val, out_var,
        input  out_last, bt_done, bt_empty, count, level, full, empty, overflow
    );

    modport slave (
        input  push_valid, push_type, push_val, push_var, bt_req,
`ifdef TRAIL_BACKJUMP_EN
        input  bt_level,
`endif
        input  out_ready,
        output push_ready, bt_busy, out_valid, out_type, out_val, out_var,
        output out_last, bt_done, bt_empty, count, level, full, empty, overflow
    );
endinterface

// File: rtl/sat_trail_stack.sv
// Assignment trail for the DPLL core: records decision/forced entries and streams them back on backtrack.
// Define TRAIL_BACKJUMP_EN to backjump to trail.bt_level instead of undoing only the latest decision.
module sat_trail_stack #(
    parameter int NUM_VARS = 128,
    parameter int VAR_W    = 7,
    parameter int CNT_W    = $clog2(NUM_VARS + 1)
) (
    input logic          clk,
    input logic          reset,
    sat_trail_stack_if.slave trail
);
    localparam int AW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_VARS);

    typedef enum logic [1:0] {IDLE, BT, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             overflow_q;
    logic             bt_done_q;
    logic             bt_empty_q;
`ifdef TRAIL_BACKJUMP_EN
    logic [CNT_W-1:0] bt_level_q;
`endif

    // Entry layout: {type, val, var}; type 0 = decision.
    logic [VAR_W+1:0] mem_q [NUM_VARS];
    logic [VAR_W+1:0] top;
    logic [AW-1:0]    wr_idx, top_idx;
    logic             is_full, is_empty, push_fire, pop_fire, top_is_dec, stop_here;

    assign is_full    = (count_q == FULL_CNT);
    assign is_empty   = (count_q == '0);
    assign wr_idx     = count_q[AW-1:0];
    assign top_idx    = wr_idx - AW'(1);
    assign top        = mem_q[top_idx];
    assign top_is_dec = !top[VAR_W+1];

`ifdef TRAIL_BACKJUMP_EN
    assign stop_here = top_is_dec && (level_q == bt_level_q + 1'b1);
`else
    assign stop_here = top_is_dec;
`endif

    assign trail.push_ready = (state_q == IDLE) && !is_full && !trail.bt_req;
    assign trail.out_valid  = (state_q == BT) && !is_empty;
    assign trail.out_type   = trail.out_valid & top[VAR_W+1];
    assign trail.out_val    = trail.out_valid & top[VAR_W];
    assign trail.out_var    = trail.out_valid ? top[VAR_W-1:0] : '0;
    assign trail.out_last   = trail.out_valid & stop_here;
    assign trail.bt_busy    = (state_q != IDLE);
    assign trail.bt_done    = bt_done_q;
    assign trail.bt_empty   = bt_empty_q;
    assign trail.count      = count_q;
    assign trail.level      = level_q;
    assign trail.full       = is_full;
    assign trail.empty      = is_empty;
    assign trail.overflow   = overflow_q;

    assign push_fire = trail.push_valid && trail.push_ready;
    assign pop_fire  = trail.out_valid && trail.out_ready;

    always_comb begin
        count_d = count_q;
        level_d = level_q;
        if (push_fire) begin
            count_d = count_q + 1'b1;
            if (!trail.push_type) level_d = level_q + 1'b1;
        end else if (pop_fire) begin
            count_d = count_q - 1'b1;
            if (top_is_dec) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_idx] <= {trail.push_type, trail.push_val, trail.push_var};
    end

    // bt_done/bt_empty are raised on the transition into DONE so they are high exactly during DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            bt_done_q  <= 1'b0;
            bt_empty_q <= 1'b0;
`ifdef TRAIL_BACKJUMP_EN
            bt_level_q <= '0;
`endif
        end else begin
            count_q    <= count_d;
            level_q    <= level_d;
            bt_done_q  <= 1'b0;
            bt_empty_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trail.push_valid && is_full) overflow_q <= 1'b1;
                    if (trail.bt_req) begin
`ifdef TRAIL_BACKJUMP_EN
                        bt_level_q <= trail.bt_level;
                        if (trail.bt_level >= level_q) begin
                            state_q   <= DONE;
                            bt_done_q <= 1'b1;
                        end else begin
                            state_q <= BT;
                        end
`else
                        state_q <= BT;
`endif
                    end
                end
                BT: begin
                    if (is_empty) begin
                        state_q    <= DONE;
                        bt_done_q  <= 1'b1;
                        bt_empty_q <= 1'b1;
                    end else if (pop_fire && stop_here) begin
                        state_q   <= DONE;
                        bt_done_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sat_trail_stack.sv
// Directed bench for sat_trail_stack with a model trail and a queue of expected backtrack beats.
// Builds with or without TRAIL_BACKJUMP_EN.
module tb_sat_trail_stack;
    localparam int NUM_VARS = 128;
    localparam int VAR_W    = 7;
    localparam int CNT_W    = 8;
    localparam int MAXC     = 400;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sat_trail_stack_if #(.VAR_W(VAR_W), .CNT_W(CNT_W)) ifc ();

    sat_trail_stack #(.NUM_VARS(NUM_VARS), .VAR_W(VAR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .trail (ifc)
    );

    typedef struct packed {logic t; logic v; logic [VAR_W-1:0] x;} ent_t;
    typedef struct packed {ent_t e; logic last;} beat_t;

    ent_t  m_stk[$];
    beat_t exp_q[$];
    int    m_level;
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, 32'(ifc.count), 32'(m_stk.size()));
        chk({tag, "_level"}, 32'(ifc.level), 32'(m_level));
        chk({tag, "_full"},  32'(ifc.full),  32'(m_stk.size() == NUM_VARS));
        chk({tag, "_empty"}, 32'(ifc.empty), 32'(m_stk.size() == 0));
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        ifc.push_valid = 1'b0;
        ifc.push_type  = 1'b0;
        ifc.push_val   = 1'b0;
        ifc.push_var   = '0;
        ifc.bt_req     = 1'b0;
        ifc.out_ready  = 1'b1;
`ifdef TRAIL_BACKJUMP_EN
        ifc.bt_level   = '0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_stk.delete();
        m_level = 0;
    endtask

    task automatic push_e(input logic t, input logic v, input logic [VAR_W-1:0] x);
        ent_t e;
        bit   acc;
        acc = (m_stk.size() < NUM_VARS);
        e.t = t; e.v = v; e.x = x;
        ifc.push_valid = 1'b1;
        ifc.push_type  = t;
        ifc.push_val   = v;
        ifc.push_var   = x;
        #1;
        chk("push_ready", 32'(ifc.push_ready), 32'(acc));
        @(negedge clk);
        ifc.push_valid = 1'b0;
        if (acc) begin
            m_stk.push_back(e);
            if (!t) m_level++;
        end
    endtask

    task automatic backtrack(input int bt_lvl, input int stall_n, input bit with_push);
        ent_t  e;
        beat_t b;
        bit    dry, immediate, hitd;
        int    nb, exp_idx, idx, stall_left, cnt0;
        exp_q.delete();
        dry = 0; immediate = 0; hitd = 0;
        cnt0 = m_stk.size();
`ifdef TRAIL_BACKJUMP_EN
        if (bt_lvl >= m_level) immediate = 1;
        else begin
            while (m_level > bt_lvl && m_stk.size() > 0) begin
                e = m_stk.pop_back();
                if (!e.t) m_level--;
                b.e = e; b.last = !e.t && (m_level == bt_lvl);
                exp_q.push_back(b);
            end
            dry = (m_level > bt_lvl);
        end
`else
        while (!hitd && m_stk.size() > 0) begin
            e = m_stk.pop_back();
            if (!e.t) begin m_level--; hitd = 1; end
            b.e = e; b.last = hitd;
            exp_q.push_back(b);
        end
        dry = !hitd;
`endif
        nb = exp_q.size();
        exp_idx = immediate ? 0 : (dry ? nb + 1 : nb) + ((stall_n > 0 && nb > 0) ? stall_n - 1 : 0);

        if (stall_n > 0) ifc.out_ready = 1'b0;
        ifc.bt_req = 1'b1;
`ifdef TRAIL_BACKJUMP_EN
        ifc.bt_level = CNT_W'(bt_lvl);
`endif
        if (with_push) begin
            ifc.push_valid = 1'b1;
            ifc.push_type  = 1'b1;
            ifc.push_val   = 1'b1;
            ifc.push_var   = 7'd99;
        end
        #1;
        chk("bt_push_ready", 32'(ifc.push_ready), 32'd0);
        @(negedge clk);
        ifc.bt_req     = 1'b0;
        ifc.push_valid = 1'b0;
        chk("first_valid", 32'(ifc.out_valid), 32'(nb > 0));

        stall_left = stall_n;
        idx = 0;
        while (idx < MAXC && !ifc.bt_done) begin
            if (stall_left > 0 && ifc.out_valid) begin
                chk("stall_var", 32'(ifc.out_var), 32'(exp_q[0].e.x));
                chk("stall_cnt", 32'(ifc.count), 32'(cnt0));
                stall_left--;
                if (stall_left == 0) ifc.out_ready = 1'b1;
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 32'(ifc.out_valid), 32'd0);
                else begin
                    b = exp_q.pop_front();
                    chk("beat_type", 32'(ifc.out_type), 32'(b.e.t));
                    chk("beat_val",  32'(ifc.out_val),  32'(b.e.v));
                    chk("beat_var",  32'(ifc.out_var),  32'(b.e.x));
                    chk("beat_last", 32'(ifc.out_last), 32'(b.last));
                end
            end
            @(negedge clk);
            idx++;
        end
        chk("done_lat",   32'(idx), 32'(exp_idx));
        chk("bt_done",    32'(ifc.bt_done), 32'd1);
        chk("bt_empty",   32'(ifc.bt_empty), 32'(dry));
        chk("done_valid", 32'(ifc.out_valid), 32'd0);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("done_pulse", 32'(ifc.bt_done), 32'd0);
        chk("idle_busy",  32'(ifc.bt_busy), 32'd0);
        chk_state("post_bt");
    endtask

    initial begin
        reset          = 1'b1;
        ifc.push_valid = 1'b0;
        ifc.push_type  = 1'b0;
        ifc.push_val   = 1'b0;
        ifc.push_var   = '0;
        ifc.bt_req     = 1'b0;
        ifc.out_ready  = 1'b1;
`ifdef TRAIL_BACKJUMP_EN
        ifc.bt_level   = '0;
`endif
        @(negedge clk);
        do_reset();

        chk_state("rst");
        chk("rst_overflow",  32'(ifc.overflow),   32'd0);
        chk("rst_out_valid", 32'(ifc.out_valid),  32'd0);
        chk("rst_out_var",   32'(ifc.out_var),    32'd0);
        chk("rst_busy",      32'(ifc.bt_busy),    32'd0);
        chk("rst_done",      32'(ifc.bt_done),    32'd0);
        chk("rst_bt_empty",  32'(ifc.bt_empty),   32'd0);
        chk("rst_push_rdy",  32'(ifc.push_ready), 32'd1);

        // Chronological undo of one decision with two implications
        push_e(1'b0, 1'b1, 7'd3);
        push_e(1'b1, 1'b0, 7'd5);
        push_e(1'b1, 1'b1, 7'd9);
        chk_state("t1_push");
        backtrack(0, 0, 0);

        // Two decision levels, undone one at a time
        push_e(1'b0, 1'b0, 7'd1);
        push_e(1'b0, 1'b1, 7'd2);
        push_e(1'b1, 1'b1, 7'd4);
        chk_state("t2_push");
        backtrack(1, 0, 0);
        backtrack(0, 0, 0);

        // Backtrack on an empty trail
        backtrack(0, 0, 0);

        // Stalled consumer plus a push racing bt_req
        push_e(1'b0, 1'b1, 7'd7);
        push_e(1'b1, 1'b0, 7'd8);
        backtrack(0, 3, 1);

        // Three levels, jump back to level 1
        push_e(1'b0, 1'b1, 7'd11);
        push_e(1'b1, 1'b0, 7'd12);
        push_e(1'b0, 1'b1, 7'd13);
        push_e(1'b1, 1'b0, 7'd14);
        push_e(1'b0, 1'b0, 7'd15);
        push_e(1'b1, 1'b1, 7'd16);
        chk_state("t6_push");
        backtrack(1, 0, 0);

        // Fill to capacity, then overflow
        do_reset();
        for (int i = 0; i < NUM_VARS; i++)
            push_e(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'(i));
        chk_state("full");
        push_e(1'b0, 1'b1, 7'd5);
        chk("ovf_set",   32'(ifc.overflow), 32'd1);
        chk_state("ovf");
        @(negedge clk);
        chk("ovf_sticky", 32'(ifc.overflow), 32'd1);
        backtrack((m_level > 0) ? m_level - 1 : 0, 0, 0);
        chk("ovf_sticky_bt", 32'(ifc.overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(ifc.overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sat_trail_stack.md
Name: sat_trail_stack

Overview:
- Parametrised assignment trail for the DPLL SAT core.
- Records every variable assignment as either a decision (D) or a forced/implied assignment (F), and tracks the current decision level.
- On a conflict, streams popped entries back to the variable-assignment unit with a valid/ready handshake until the backtrack target is reached.
- Sits between the BCP/decision logic (push side) and the assignment memory (unassign side).

Parameters:
- NUM_VARS, 128, number of solver variables; also sets trail depth (one entry per variable max).
- VAR_W, 7, variable index width; must satisfy 2**VAR_W >= NUM_VARS.
- CNT_W, $clog2(NUM_VARS+1), width of the entry counter and the level counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- push_valid  in  1  push request
- push_ready  out  1  push accepted when push_valid && push_ready
- push_type  in  1  0=decision, 1=forced
- push_val  in  1  assigned value
- push_var  in  VAR_W  variable index
- bt_req  in  1  start a backtrack; sampled only in IDLE
- bt_busy  out  1  high while not IDLE
- out_valid  out  1  popped entry valid
- out_ready  in  1  consumer accepts the popped entry
- out_type / out_val / out_var  out  1/1/VAR_W  popped entry fields
- out_last  out  1  current beat is the final entry of this backtrack
- bt_done  out  1  one-cycle pulse at the end of a backtrack
- bt_empty  out  1  one-cycle pulse with bt_done when the trail ran dry (UNSAT indication)
- count  out  CNT_W  entries currently stored
- level  out  CNT_W  current decision level (number of D entries stored)
- full / empty  out  1  count==NUM_VARS / count==0
- overflow  out  1  sticky error flag

Behaviour:
- Reset values: count=0, level=0, empty=1, full=0, overflow=0, all pulses and out_* =0, state=IDLE. Reset mid-backtrack aborts immediately; trail contents become don't-care.
- States: IDLE, BT, DONE.
- IDLE:
  - push_ready = !full.
  - An accepted push writes {type,val,var} at index count; count+1 next cycle; level+1 if type=0.
  - push_valid while full: no write, overflow<=1.
  - bt_req asserted: state<=BT next cycle. bt_req has priority over a simultaneous push; that push is not accepted, since push_ready=0 whenever bt_req=1.
- BT:
  - push_ready=0.
  - If count==0: out_valid=0; next cycle is DONE with bt_empty.
  - Else out_valid=1 and out_* = stack[count-1] (combinational read of the top entry).
  - out_last=1 when the top entry is a decision.
  - Beat completes on out_valid && out_ready: count-1. If the entry was a decision: level-1, state<=DONE.
  - Stalls (out_ready=0) hold all outputs stable.
  - One beat per cycle maximum.
- DONE: bt_done=1 for exactly one cycle (bt_empty=1 in the same cycle if the trail emptied); state<=IDLE.
- Latency: first out_valid appears 1 cycle after bt_req is sampled; bt_done appears 1 cycle after the last beat's handshake.
- count and level never wrap: pops only occur while count>0, and level only decrements when a D entry is popped.

Optional Feature:
- Macro TRAIL_BACKJUMP_EN.
- When defined, adds input bt_level (CNT_W): non-chronological backjump.
  - BT pops entries until level==bt_level; the final popped D entry carries out_last.
  - If bt_level>=level at bt_req, go to DONE directly with no beats.
  - bt_level is sampled and held with bt_req.
- When not defined: chronological backtrack, stopping after the first D entry popped.

Test Plan:
- Push D(v3,1), F(v5,0), F(v9,1), then bt_req with out_ready=1 -> beats v9, v5, v3 (out_last only on v3); bt_done 1 cycle after; count=0, level=0, bt_empty=0.
- Push D(v1,0), D(v2,1), F(v4,1), bt_req -> beats v4, v2(last); count=1, level=1; a second bt_req -> v1(last).
- Trail empty, bt_req -> no out_valid; bt_done=1 and bt_empty=1 in the same cycle, 2 cycles after bt_req.
- Push 128 entries -> full=1, push_ready=0; a 129th push_valid -> overflow=1 (sticky), count stays 128.
- During BT, hold out_ready=0 for 3 cycles -> out_* stable, count unchanged; bt_req and push_valid in the same IDLE cycle -> push not accepted.
- TRAIL_BACKJUMP_EN: levels D1,F,D2,F,D3,F, bt_level=1 -> 4 beats ending at D2 (last); level=1, count=2.
